// File: rtl/vdu_mem_arbiter_pkg.sv
// vdu_mem_arbiter_pkg: shared constants, read-source enum and address helper for the display RAM arbiter
package vdu_mem_arbiter_pkg;
    localparam int          ADDR_W_DEF    = 9;
    localparam logic [15:0] BASE_ADDR_DEF = 16'h0200;
    typedef enum logic [1:0] {SRC_NONE, SRC_VDU, SRC_CPU_MEM, SRC_CPU_FWD} rd_src_e;
    // Full 16-bit offset; callers keep the low ADDR_W bits and may check the rest for window escapes
    function automatic logic [15:0] to_mem_addr(input logic [15:0] addr, input logic [15:0] base);
        return addr - base;
    endfunction
endpackage

// File: rtl/vdu_mem_arbiter_if.sv
// vdu_mem_arbiter_if: CPU ready/valid bus to the display RAM arbiter
// Ports: req/we/addr/wdata from CPU, ready/rvalid/rdata back to CPU
interface vdu_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic        rvalid;
    logic [7:0]  rdata;
    modport master (output req, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/vdu_mem_arbiter_wr_buf.sv
// vdu_mem_arbiter_wr_buf: one-entry posted write buffer with load, coalesce, drain and hit detect
// Ports: load/ld_addr/ld_data write the entry, drain empties it, hit compares cmp_addr to the entry
module vdu_mem_arbiter_wr_buf
    import vdu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              load,
    input  logic              drain,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              hit
);
    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [7:0]        data_d, data_q;
    // A load in the drain cycle refills the entry, so load wins over drain
    always_comb begin
        valid_d = load || (valid_q && !drain);
        addr_d  = load ? ld_addr : addr_q;
        data_d  = load ? ld_data : data_q;
        hit     = valid_q && addr_q == cmp_addr;
        valid   = valid_q;
        addr    = addr_q;
        data    = data_q;
    end
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/vdu_mem_arbiter.sv
// vdu_mem_arbiter: shares the single-port display RAM between VDU scan-out and the CPU bus
// Ports: clk_pix/rst_pix; vdu_read_en/vdu_read_addr -> vdu_data (1-cycle latency);
//        cpu (slave modport, ready/valid); mem_en/mem_we/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM
module vdu_mem_arbiter
    import vdu_mem_arbiter_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              vdu_read_en,
    input  logic [15:0]       vdu_read_addr,
    output logic [7:0]        vdu_data,
    vdu_mem_arbiter_if.slave  cpu,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    logic [15:0]       vdu_off, cpu_off;
    logic [ADDR_W-1:0] vdu_ma, cpu_ma, wb_addr;
    logic [7:0]        wb_data;
    logic              wb_valid, wb_hit, wb_load;
    logic              vdu_gnt, wr_acc, rd_acc, rd_hit, rd_miss, drain;
    rd_src_e           rd_src_d, rd_src_q;
    logic              fwd_d, fwd_q;
    logic [7:0]        fwd_data_d, fwd_data_q;
    assign vdu_off = to_mem_addr(vdu_read_addr, BASE_ADDR);
    assign cpu_off = to_mem_addr(cpu.addr, BASE_ADDR);
    assign vdu_ma  = vdu_off[ADDR_W-1:0];
    assign cpu_ma  = cpu_off[ADDR_W-1:0];
    vdu_mem_arbiter_wr_buf #(.ADDR_W(ADDR_W)) u_wr_buf (
        .clk_pix  (clk_pix),
        .rst_pix  (rst_pix),
        .load     (wb_load),
        .drain    (drain),
        .ld_addr  (cpu_ma),
        .ld_data  (cpu.wdata),
        .cmp_addr (cpu_ma),
        .valid    (wb_valid),
        .addr     (wb_addr),
        .data     (wb_data),
        .hit      (wb_hit)
    );
    always_comb begin
        // Grants are masked while reset is held so the RAM port goes quiet immediately
        vdu_gnt   = vdu_read_en && !rst_pix;
        // Write path assumes a drain whenever the VDU is idle (a write never coexists with a read miss)
        cpu.ready = !rst_pix && (wb_hit || !vdu_read_en || (cpu.we && !wb_valid));
        wr_acc    = cpu.req && cpu.ready && cpu.we;
        rd_acc    = cpu.req && cpu.ready && !cpu.we;
        rd_hit    = rd_acc && wb_hit;
        rd_miss   = rd_acc && !wb_hit;
        drain     = wb_valid && !vdu_gnt && !rd_miss;
        // Coalescing write in a drain cycle goes straight to RAM instead of refilling the buffer
        wb_load   = wr_acc && !(wb_hit && drain);
        mem_en    = vdu_gnt || rd_miss || drain;
        mem_we    = drain;
        mem_addr  = vdu_gnt ? vdu_ma : rd_miss ? cpu_ma : drain ? wb_addr : '0;
        mem_wdata = drain ? ((wr_acc && wb_hit) ? cpu.wdata : wb_data) : 8'h00;
        rd_src_d  = vdu_gnt ? SRC_VDU : rd_miss ? SRC_CPU_MEM : rd_hit ? SRC_CPU_FWD : SRC_NONE;
        // A forwarded hit can coincide with a VDU grant, so it is tracked beside rd_src
        fwd_d      = rd_hit;
        fwd_data_d = rd_hit ? wb_data : fwd_data_q;
        cpu.rvalid = rd_src_q == SRC_CPU_MEM || fwd_q;
        cpu.rdata  = rd_src_q == SRC_CPU_MEM ? mem_rdata : fwd_data_q;
        vdu_data   = rd_src_q == SRC_VDU ? mem_rdata : 8'h00;
    end
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            rd_src_q   <= SRC_NONE;
            fwd_q      <= 1'b0;
            fwd_data_q <= 8'h00;
        end else begin
            rd_src_q   <= rd_src_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end
    a_cpu_window: assert property (@(posedge clk_pix) disable iff (rst_pix)
        cpu.req |-> (cpu_off >> ADDR_W) == 16'd0);
    a_vdu_window: assert property (@(posedge clk_pix) disable iff (rst_pix)
        vdu_read_en |-> (vdu_off >> ADDR_W) == 16'd0);
endmodule

// File: tb/tb_vdu_mem_arbiter.sv
// tb_vdu_mem_arbiter: directed vectors, corner sequences and random traffic against a RAM model
module tb_vdu_mem_arbiter;
    logic        clk_pix = 1'b0;
    logic        rst_pix = 1'b1;
    logic        vdu_read_en;
    logic [15:0] vdu_read_addr;
    logic [7:0]  vdu_data;
    logic        mem_en, mem_we;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  ram [512];
    logic [7:0]  cpu_view [512];
    int          errors = 0;
    int          checks = 0;

    vdu_mem_arbiter_if bus();

    vdu_mem_arbiter #(.BASE_ADDR(16'h0200), .ADDR_W(9)) dut (
        .clk_pix       (clk_pix),
        .rst_pix       (rst_pix),
        .vdu_read_en   (vdu_read_en),
        .vdu_read_addr (vdu_read_addr),
        .vdu_data      (vdu_data),
        .cpu           (bus),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        ven;
        logic [15:0] va;
        logic        req;
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rdy;
        logic        en;
        logic        mwe;
        logic [8:0]  maddr;
        logic [7:0]  mwd;
        logic        rv;
        logic [7:0]  rd;
        logic        vchk;
        logic [7:0]  vd;
    } vec_t;
    vec_t tab [13];

    function automatic logic [7:0] init_val(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ven, input logic [15:0] va, input logic req, input logic we,
                         input logic [15:0] a, input logic [7:0] d);
        vdu_read_en   = ven;
        vdu_read_addr = va;
        bus.req       = req;
        bus.we        = we;
        bus.addr      = a;
        bus.wdata     = d;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0200, 1'b0, 1'b0, 16'h0200, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        logic        pv, pend, acc;
        logic [7:0]  pv_exp, pend_exp;
        logic        ven, req, we;
        logic [15:0] va, a;
        logic [7:0]  d;
        for (int i = 0; i < 512; i++) ram[i] = init_val(i);
        //               ven  va        req  we   a         d      rdy  en   mwe  maddr   mwd    rv   rd     vchk vd
        tab[0]  = '{1'b0,16'h0200,1'b0,1'b0,16'h0200,8'h00, 1'b1,1'b0,1'b0,9'h000,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tab[1]  = '{1'b0,16'h0200,1'b1,1'b0,16'h0203,8'h00, 1'b1,1'b1,1'b0,9'h003,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tab[2]  = '{1'b1,16'h0210,1'b1,1'b0,16'h0204,8'h00, 1'b0,1'b1,1'b0,9'h010,8'h00, 1'b1,8'h59, 1'b0,8'h00};
        tab[3]  = '{1'b0,16'h0200,1'b1,1'b1,16'h0205,8'hA5, 1'b1,1'b0,1'b0,9'h000,8'h00, 1'b0,8'h00, 1'b1,8'h4A};
        tab[4]  = '{1'b1,16'h0211,1'b1,1'b0,16'h0205,8'h00, 1'b1,1'b1,1'b0,9'h011,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tab[5]  = '{1'b1,16'h0212,1'b1,1'b1,16'h0206,8'h77, 1'b0,1'b1,1'b0,9'h012,8'h00, 1'b1,8'hA5, 1'b1,8'h4B};
        tab[6]  = '{1'b0,16'h0200,1'b0,1'b0,16'h0200,8'h00, 1'b1,1'b1,1'b1,9'h005,8'hA5, 1'b0,8'h00, 1'b1,8'h48};
        tab[7]  = '{1'b0,16'h0200,1'b1,1'b0,16'h0205,8'h00, 1'b1,1'b1,1'b0,9'h005,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tab[8]  = '{1'b0,16'h0200,1'b1,1'b1,16'h0208,8'h10, 1'b1,1'b0,1'b0,9'h000,8'h00, 1'b1,8'hA5, 1'b0,8'h00};
        tab[9]  = '{1'b0,16'h0200,1'b1,1'b1,16'h0208,8'h20, 1'b1,1'b1,1'b1,9'h008,8'h20, 1'b0,8'h00, 1'b0,8'h00};
        tab[10] = '{1'b0,16'h0200,1'b0,1'b0,16'h0200,8'h00, 1'b1,1'b0,1'b0,9'h000,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tab[11] = '{1'b0,16'h0200,1'b1,1'b0,16'h0208,8'h00, 1'b1,1'b1,1'b0,9'h008,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tab[12] = '{1'b0,16'h0200,1'b0,1'b0,16'h0200,8'h00, 1'b1,1'b0,1'b0,9'h000,8'h00, 1'b1,8'h20, 1'b0,8'h00};

        // reset: VDU strobe held high must not reach the RAM port
        drive(1'b1, 16'h0210, 1'b0, 1'b0, 16'h0200, 8'h00);
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        idle();
        rst_pix = 1'b0;
        tick();

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(tab[i].ven, tab[i].va, tab[i].req, tab[i].we, tab[i].a, tab[i].d);
            @(negedge clk_pix);
            chk($sformatf("v%0d_ready", i), bus.ready, tab[i].rdy);
            chk($sformatf("v%0d_mem_en", i), mem_en, tab[i].en);
            chk($sformatf("v%0d_mem_we", i), mem_we, tab[i].mwe);
            if (tab[i].en) chk($sformatf("v%0d_mem_addr", i), mem_addr, tab[i].maddr);
            if (tab[i].mwe) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tab[i].mwd);
            chk($sformatf("v%0d_rvalid", i), bus.rvalid, tab[i].rv);
            if (tab[i].rv) chk($sformatf("v%0d_rdata", i), bus.rdata, tab[i].rd);
            if (tab[i].vchk) chk($sformatf("v%0d_vdu_data", i), vdu_data, tab[i].vd);
            tick();
        end

        // VDU burst starves a pending CPU read miss
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 16'h0210 + 16'(k), 1'b1, 1'b0, 16'h0203, 8'h00);
            @(negedge clk_pix);
            chk($sformatf("burst%0d_ready", k), bus.ready, 0);
            if (k > 0) chk($sformatf("burst%0d_vdu", k), vdu_data, init_val(16'h10 + k - 1));
            tick();
        end
        drive(1'b0, 16'h0200, 1'b1, 1'b0, 16'h0203, 8'h00);
        @(negedge clk_pix);
        chk("burst_end_ready", bus.ready, 1);
        chk("burst_end_vdu", vdu_data, init_val(16'h1F));
        tick();
        idle();
        @(negedge clk_pix);
        chk("burst_rvalid", bus.rvalid, 1);
        chk("burst_rdata", bus.rdata, init_val(3));
        tick();

        // second write to a different address waits for a drain; same address coalesces
        drive(1'b1, 16'h0220, 1'b1, 1'b1, 16'h0201, 8'h11);
        @(negedge clk_pix); chk("wb_first_ready", bus.ready, 1); tick();
        drive(1'b1, 16'h0221, 1'b1, 1'b1, 16'h0202, 8'h22);
        @(negedge clk_pix); chk("wb_full_ready_a", bus.ready, 0); tick();
        drive(1'b1, 16'h0222, 1'b1, 1'b1, 16'h0202, 8'h22);
        @(negedge clk_pix); chk("wb_full_ready_b", bus.ready, 0); tick();
        drive(1'b0, 16'h0200, 1'b1, 1'b1, 16'h0202, 8'h22);
        @(negedge clk_pix);
        chk("wb_drain_ready", bus.ready, 1);
        chk("wb_drain1_we", mem_we, 1);
        chk("wb_drain1_addr", mem_addr, 1);
        chk("wb_drain1_data", mem_wdata, 8'h11);
        tick();
        idle();
        @(negedge clk_pix);
        chk("wb_drain2_we", mem_we, 1);
        chk("wb_drain2_addr", mem_addr, 2);
        chk("wb_drain2_data", mem_wdata, 8'h22);
        tick();
        drive(1'b1, 16'h0223, 1'b1, 1'b1, 16'h0201, 8'h11);
        @(negedge clk_pix); chk("co_first_ready", bus.ready, 1); tick();
        drive(1'b1, 16'h0224, 1'b1, 1'b1, 16'h0201, 8'h99);
        @(negedge clk_pix);
        chk("co_second_ready", bus.ready, 1);
        chk("co_no_early_we", mem_we, 0);
        tick();
        idle();
        @(negedge clk_pix);
        chk("co_drain_we", mem_we, 1);
        chk("co_drain_addr", mem_addr, 1);
        chk("co_drain_data", mem_wdata, 8'h99);
        tick();
        @(negedge clk_pix);
        chk("co_single_write", mem_en, 0);
        tick();
        chk("co_ram1", ram[1], 8'h99);
        chk("co_ram2", ram[2], 8'h22);

        // async reset with a full buffer and an rvalid in flight
        drive(1'b1, 16'h0225, 1'b1, 1'b1, 16'h0209, 8'hEE);
        @(negedge clk_pix); chk("rs_wr_ready", bus.ready, 1); tick();
        drive(1'b1, 16'h0226, 1'b1, 1'b0, 16'h0209, 8'h00);
        @(negedge clk_pix); chk("rs_hit_ready", bus.ready, 1); tick();
        chk("rs_pre_rvalid", bus.rvalid, 1);
        chk("rs_pre_rdata", bus.rdata, 8'hEE);
        #2 rst_pix = 1'b1;
        #1;
        chk("rs_rvalid", bus.rvalid, 0);
        chk("rs_mem_en", mem_en, 0);
        chk("rs_mem_we", mem_we, 0);
        tick();
        idle();
        @(negedge clk_pix);
        rst_pix = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk_pix);
            chk($sformatf("rs_post%0d_mem_en", k), mem_en, 0);
        end
        tick();
        drive(1'b0, 16'h0200, 1'b1, 1'b0, 16'h0209, 8'h00);
        @(negedge clk_pix);
        chk("rs_rd_ready", bus.ready, 1);
        chk("rs_rd_addr", mem_addr, 9);
        tick();
        idle();
        @(negedge clk_pix);
        chk("rs_rd_rvalid", bus.rvalid, 1);
        chk("rs_rd_rdata", bus.rdata, init_val(9));
        tick();

        // random traffic against the CPU-view scoreboard
        for (int i = 0; i < 512; i++) cpu_view[i] = ram[i];
        pv = 1'b0;
        pend = 1'b0;
        pv_exp = 8'h00;
        pend_exp = 8'h00;
        for (int n = 0; n < 20000; n++) begin
            ven = $urandom_range(0, 9) < 7;
            va  = 16'h0200 + 16'($urandom_range(0, 511));
            req = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            a   = 16'h0200 + 16'($urandom_range(0, 15));
            d   = 8'($urandom);
            drive(ven, va, req, we, a, d);
            @(negedge clk_pix);
            if (pv) chk("rnd_vdu_data", vdu_data, pv_exp);
            chk("rnd_rvalid", bus.rvalid, pend);
            if (pend) chk("rnd_rdata", bus.rdata, pend_exp);
            if (ven) chk("rnd_vdu_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, va[8:0]});
            pv     = ven;
            pv_exp = ram[va[8:0]];
            acc    = req && bus.ready;
            pend   = acc && !we;
            if (pend) pend_exp = cpu_view[a[8:0]];
            if (acc && we) cpu_view[a[8:0]] = d;
            tick();
        end
        idle();
        @(negedge clk_pix);
        chk("rnd_last_rvalid", bus.rvalid, pend);
        if (pend) chk("rnd_last_rdata", bus.rdata, pend_exp);
        repeat (3) tick();
        for (int i = 0; i < 16; i++) chk($sformatf("rnd_ram%0d", i), ram[i], cpu_view[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
